// File: rtl/bram_read_arbiter.sv
// Round-robin read arbiter sharing one single-port BRAM between two requesters.
// Tags each issued read through the BRAM latency and routes the registered response back to its issuer.
module bram_read_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rsp_valid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              bram_ena,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout
);

    logic              last_q, last_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;
    logic              rsp_valid0_q, rsp_valid0_d;
    logic              rsp_valid1_q, rsp_valid1_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Grants are gated by rst_n so nothing reaches the BRAM while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && en) begin
            if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        bram_ena  = gnt0 | gnt1;
        bram_addr = '0;
        if (gnt0) begin
            bram_addr = addr0;
        end else if (gnt1) begin
            bram_addr = addr1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    // Stage 0 holds the read issued last cycle; the top stage lines up with valid bram_dout.
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = bram_ena;
        id_d[0]  = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_comb begin
        rsp_valid0_d = vld_q[RD_LAT-1] && !id_q[RD_LAT-1];
        rsp_valid1_d = vld_q[RD_LAT-1] &&  id_q[RD_LAT-1];
        rsp_data_d   = rsp_data_q;
        if (vld_q[RD_LAT-1]) begin
            rsp_data_d = bram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            vld_q        <= '0;
            id_q         <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            last_q       <= last_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench: three arbiter copies (RD_LAT 1,2,3) share the same stimulus,
// each with its own ideal pipelined BRAM model; expectations are written per latency.
module tb_bram_read_arbiter;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              req0, req1;
    logic [2:0]        addr0, addr1;
    logic [2:0]        gnt0_w, gnt1_w, rv0_w, rv1_w, ena_w;
    logic [2:0][2:0]   baddr_w;
    logic [2:0][31:0]  rdata_w, dout_w;
    logic [31:0]       mem [8];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic [3:0][31:0] pipe;

        bram_read_arbiter #(.ADDR_W(3), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .req0       (req0),
            .addr0      (addr0),
            .gnt0       (gnt0_w[g]),
            .rsp_valid0 (rv0_w[g]),
            .req1       (req1),
            .addr1      (addr1),
            .gnt1       (gnt1_w[g]),
            .rsp_valid1 (rv1_w[g]),
            .rsp_data   (rdata_w[g]),
            .bram_ena   (ena_w[g]),
            .bram_addr  (baddr_w[g]),
            .bram_dout  (dout_w[g])
        );

        always @(posedge clk) begin
            pipe[0] <= mem[baddr_w[g]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign dout_w[g] = pipe[g];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic [2:0] a0, input logic r1,
                          input logic [2:0] a1, input logic e);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; en = e;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, lat;
        logic e0, e1;
        int n_ena [3];
        int n_g1  [3];
        int n_rv0 [3];
        int n_rv1 [3];

        for (int i = 0; i < 8; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[5] = 32'hDEAD_BEEF;

        // Reset state with both requests high
        rst_n = 1'b1;
        set_in(1'b1, 3'd3, 1'b1, 3'd4, 1'b1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("rst gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd0);
            check_eq($sformatf("rst gnt1 L%0d", g + 1), 32'(gnt1_w[g]), 32'd0);
            check_eq($sformatf("rst ena L%0d", g + 1), 32'(ena_w[g]), 32'd0);
            check_eq($sformatf("rst rv0 L%0d", g + 1), 32'(rv0_w[g]), 32'd0);
            check_eq($sformatf("rst rv1 L%0d", g + 1), 32'(rv1_w[g]), 32'd0);
            check_eq($sformatf("rst data L%0d", g + 1), rdata_w[g], 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: req0 addr 5
        set_in(1'b1, 3'd5, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("t1 gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd1);
            check_eq($sformatf("t1 gnt1 L%0d", g + 1), 32'(gnt1_w[g]), 32'd0);
            check_eq($sformatf("t1 ena L%0d", g + 1), 32'(ena_w[g]), 32'd1);
            check_eq($sformatf("t1 addr L%0d", g + 1), 32'(baddr_w[g]), 32'd5);
        end
        next_cycle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                check_eq($sformatf("t1 ena L%0d c%0d", g + 1, c), 32'(ena_w[g]), 32'd0);
                check_eq($sformatf("t1 addr L%0d c%0d", g + 1, c), 32'(baddr_w[g]), 32'd0);
                check_eq($sformatf("t1 rv0 L%0d c%0d", g + 1, c), 32'(rv0_w[g]), 32'(c == g + 2));
                check_eq($sformatf("t1 rv1 L%0d c%0d", g + 1, c), 32'(rv1_w[g]), 32'd0);
                if (c >= g + 2)
                    check_eq($sformatf("t1 data L%0d c%0d", g + 1, c), rdata_w[g], 32'hDEAD_BEEF);
            end
            next_cycle();
        end

        // Continuous tie after reset: grants 0,1,0,1...
        do_reset();
        set_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c == 8) set_in(1'b0, 3'd1, 1'b0, 3'd2, 1'b1);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lat = g + 1;
                if (c < 8) begin
                    check_eq($sformatf("t2 gnt0 L%0d c%0d", lat, c), 32'(gnt0_w[g]), 32'(c % 2 == 0));
                    check_eq($sformatf("t2 gnt1 L%0d c%0d", lat, c), 32'(gnt1_w[g]), 32'(c % 2 == 1));
                    check_eq($sformatf("t2 addr L%0d c%0d", lat, c), 32'(baddr_w[g]),
                             (c % 2 == 0) ? 32'd1 : 32'd2);
                end
                k  = c - lat - 1;
                e0 = (k >= 0) && (k < 8) && (k % 2 == 0);
                e1 = (k >= 0) && (k < 8) && (k % 2 == 1);
                check_eq($sformatf("t2 rv0 L%0d c%0d", lat, c), 32'(rv0_w[g]), 32'(e0));
                check_eq($sformatf("t2 rv1 L%0d c%0d", lat, c), 32'(rv1_w[g]), 32'(e1));
                if (e0 || e1)
                    check_eq($sformatf("t2 data L%0d c%0d", lat, c), rdata_w[g], e0 ? mem[1] : mem[2]);
            end
            next_cycle();
        end

        // Streaming: req1 held, addr1 steps 0..7
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c < 8) set_in(1'b0, 3'd0, 1'b1, 3'(c), 1'b1);
            else       set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lat = g + 1;
                if (c < 8) begin
                    check_eq($sformatf("t3 gnt1 L%0d c%0d", lat, c), 32'(gnt1_w[g]), 32'd1);
                    check_eq($sformatf("t3 addr L%0d c%0d", lat, c), 32'(baddr_w[g]), 32'(c));
                end else begin
                    check_eq($sformatf("t3 ena L%0d c%0d", lat, c), 32'(ena_w[g]), 32'd0);
                end
                k  = c - lat - 1;
                e1 = (k >= 0) && (k < 8);
                check_eq($sformatf("t3 rv1 L%0d c%0d", lat, c), 32'(rv1_w[g]), 32'(e1));
                check_eq($sformatf("t3 rv0 L%0d c%0d", lat, c), 32'(rv0_w[g]), 32'd0);
                if (e1)
                    check_eq($sformatf("t3 data L%0d c%0d", lat, c), rdata_w[g], mem[k]);
            end
            next_cycle();
        end

        // en gating: req0 granted at c0, en low c1..c4 with req1 pending
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      set_in(1'b1, 3'd3, 1'b0, 3'd0, 1'b1);
            else if (c <= 4) set_in(1'b0, 3'd0, 1'b1, 3'd6, 1'b0);
            else if (c == 5) set_in(1'b0, 3'd0, 1'b1, 3'd6, 1'b1);
            else             set_in(1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lat = g + 1;
                check_eq($sformatf("t4 gnt0 L%0d c%0d", lat, c), 32'(gnt0_w[g]), 32'(c == 0));
                check_eq($sformatf("t4 gnt1 L%0d c%0d", lat, c), 32'(gnt1_w[g]), 32'(c == 5));
                check_eq($sformatf("t4 ena L%0d c%0d", lat, c), 32'(ena_w[g]), 32'(c == 0 || c == 5));
                check_eq($sformatf("t4 addr L%0d c%0d", lat, c), 32'(baddr_w[g]),
                         (c == 0) ? 32'd3 : (c == 5) ? 32'd6 : 32'd0);
                check_eq($sformatf("t4 rv0 L%0d c%0d", lat, c), 32'(rv0_w[g]), 32'(c == lat + 1));
                check_eq($sformatf("t4 rv1 L%0d c%0d", lat, c), 32'(rv1_w[g]), 32'(c == lat + 6));
                if (c == lat + 1)
                    check_eq($sformatf("t4 data0 L%0d", lat), rdata_w[g], mem[3]);
                if (c == lat + 6)
                    check_eq($sformatf("t4 data1 L%0d", lat), rdata_w[g], mem[6]);
            end
            next_cycle();
        end

        // Reset mid-flight: no reset beforehand, so last=1 and rsp_data is non-zero going in
        set_in(1'b1, 3'd4, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            check_eq($sformatf("t5 gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd1);
        next_cycle();
        set_in(1'b1, 3'd4, 1'b1, 3'd5, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("t5 rst gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd0);
            check_eq($sformatf("t5 rst gnt1 L%0d", g + 1), 32'(gnt1_w[g]), 32'd0);
            check_eq($sformatf("t5 rst ena L%0d", g + 1), 32'(ena_w[g]), 32'd0);
            check_eq($sformatf("t5 rst rv0 L%0d", g + 1), 32'(rv0_w[g]), 32'd0);
            check_eq($sformatf("t5 rst rv1 L%0d", g + 1), 32'(rv1_w[g]), 32'd0);
            check_eq($sformatf("t5 rst data L%0d", g + 1), rdata_w[g], 32'd0);
        end
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                check_eq($sformatf("t5 rv0 L%0d c%0d", g + 1, c), 32'(rv0_w[g]), 32'd0);
                check_eq($sformatf("t5 rv1 L%0d c%0d", g + 1, c), 32'(rv1_w[g]), 32'd0);
            end
            next_cycle();
        end
        set_in(1'b1, 3'd2, 1'b1, 3'd7, 1'b1);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("t5 tie gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd1);
            check_eq($sformatf("t5 tie gnt1 L%0d", g + 1), 32'(gnt1_w[g]), 32'd0);
            check_eq($sformatf("t5 tie addr L%0d", g + 1), 32'(baddr_w[g]), 32'd2);
        end
        next_cycle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        for (int c = 9; c < 14; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lat = g + 1;
                check_eq($sformatf("t5 rv0 L%0d c%0d", lat, c), 32'(rv0_w[g]), 32'(c == lat + 9));
                if (c == lat + 9)
                    check_eq($sformatf("t5 data L%0d", lat), rdata_w[g], mem[2]);
            end
            next_cycle();
        end

        // Withdrawn request: req1 loses the tie then drops
        do_reset();
        for (int g = 0; g < 3; g++) begin
            n_ena[g] = 0; n_g1[g] = 0; n_rv0[g] = 0; n_rv1[g] = 0;
        end
        for (int c = 0; c < 7; c++) begin
            if (c == 0) set_in(1'b1, 3'd2, 1'b1, 3'd7, 1'b1);
            else        set_in(1'b0, 3'd2, 1'b0, 3'd7, 1'b1);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (c == 0) begin
                    check_eq($sformatf("t6 gnt0 L%0d", g + 1), 32'(gnt0_w[g]), 32'd1);
                    check_eq($sformatf("t6 addr L%0d", g + 1), 32'(baddr_w[g]), 32'd2);
                end
                n_ena[g] += int'(ena_w[g]);
                n_g1[g]  += int'(gnt1_w[g]);
                n_rv0[g] += int'(rv0_w[g]);
                n_rv1[g] += int'(rv1_w[g]);
            end
            next_cycle();
        end
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("t6 ena count L%0d", g + 1), 32'(n_ena[g]), 32'd1);
            check_eq($sformatf("t6 gnt1 count L%0d", g + 1), 32'(n_g1[g]), 32'd0);
            check_eq($sformatf("t6 rv0 count L%0d", g + 1), 32'(n_rv0[g]), 32'd1);
            check_eq($sformatf("t6 rv1 count L%0d", g + 1), 32'(n_rv1[g]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
